// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: sequential fetch into a DEPTH-entry prefetch queue feeding decode.
// Define IF_PERF_CNT_EN to add saturating stall/flush performance counters.
module if_prefetch_unit #(
  parameter int unsigned          PC_WIDTH   = 16,
  parameter int unsigned          INST_WIDTH = 16,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0]  PC_STEP    = PC_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ready,
  input  logic                  jump_reg,
  input  logic                  jump,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   jr_target,
  input  logic [PC_WIDTH-1:0]   jump_target,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [INST_WIDTH-1:0] if_inst,
  output logic [PC_WIDTH-1:0]   if_pc,
  output logic [PC_WIDTH-1:0]   if_next_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         occ_q;
  logic [PC_WIDTH-1:0]   fetch_pc_q, inflight_pc_q, last_pc_q, redirect_target;
  logic [INST_WIDTH-1:0] last_inst_q;
  logic                  inflight_q;
  logic                  redirect, push, pop, credit;

  assign redirect = jump_reg | jump | branch_taken;

  always_comb begin
    redirect_target = branch_target;
    if (jump_reg) begin
      redirect_target = jr_target;
    end else if (jump) begin
      redirect_target = jump_target;
    end
  end

  assign if_valid = (occ_q != '0);
  assign push     = inflight_q & ~redirect;
  assign pop      = if_valid & id_ready & ~redirect;

  // Pop lookahead lets fetch keep one request per cycle even with the queue nearly full.
  assign credit   = (SW'(occ_q) + SW'(inflight_q)) < (SW'(DEPTH) + SW'(if_valid & id_ready));
  assign imem_req  = credit & ~redirect & ~rst;
  assign imem_addr = fetch_pc_q;

  // Hold the last presented entry while the queue is empty.
  assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q]   : last_pc_q;
  assign if_inst    = if_valid ? inst_mem_q[rd_ptr_q] : last_inst_q;
  assign if_next_pc = if_pc + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      last_pc_q     <= '0;
      last_inst_q   <= '0;
    end else begin
      last_pc_q   <= if_pc;
      last_inst_q <= if_inst;
      if (redirect) begin
        fetch_pc_q <= redirect_target;
        inflight_q <= 1'b0;
        occ_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        inflight_q <= imem_req;
        if (imem_req) begin
          inflight_pc_q <= fetch_pc_q;
          fetch_pc_q    <= fetch_pc_q + PC_STEP;
        end
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        occ_q <= occ_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Credit accounting must make a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && occ_q == CW'(DEPTH)));

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (if_valid && !id_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect && perf_flush_cnt != '1)               perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: directed phases plus random traffic against a
// queue-based reference model of the fetch stage.
module tb_if_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_ready = 1'b0, jump_reg = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic [15:0] jr_target = '0, jump_target = '0, branch_target = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        if_valid;
  logic [15:0] if_inst, if_pc, if_next_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  if_prefetch_unit #(
    .PC_WIDTH   (16),
    .INST_WIDTH (16),
    .DEPTH      (DEPTH),
    .RESET_PC   (16'h0000),
    .PC_STEP    (16'h0001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_ready      (id_ready),
    .jump_reg      (jump_reg),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jr_target     (jr_target),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_inst       (if_inst),
    .if_pc         (if_pc),
    .if_next_pc    (if_next_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inst_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  // One-cycle-latency memory; garbage on cycles with no request.
  always @(posedge clk) imem_rdata <= imem_req ? inst_of(imem_addr) : 16'($urandom);

  // Reference model: fetch address, one in-flight slot, unbounded PC queue.
  logic [15:0] m_fetch, m_inf_pc, m_last_pc, m_last_inst;
  bit          m_inf;
  logic [15:0] m_q[$];
  int unsigned m_stall, m_flush;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 16'h0000; m_inf = 1'b0; m_inf_pc = '0;
    m_q.delete();
    m_last_pc = '0; m_last_inst = '0;
    m_stall = 0; m_flush = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
    chk("rst_if_pc", 32'(if_pc), 32'd0);
    chk("rst_if_inst", 32'(if_inst), 32'd0);
    chk("rst_if_next_pc", 32'(if_next_pc), 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input bit rdy, input bit jr, input bit j, input bit bt,
                      input logic [15:0] tjr, input logic [15:0] tj, input logic [15:0] tbt);
    bit          redir, valid, pop, req;
    logic [15:0] epc, einst;
    id_ready = rdy; jump_reg = jr; jump = j; branch_taken = bt;
    jr_target = tjr; jump_target = tj; branch_target = tbt;
    #4;
    redir = jr | j | bt;
    valid = m_q.size() > 0;
    epc   = valid ? m_q[0] : m_last_pc;
    einst = valid ? inst_of(m_q[0]) : m_last_inst;
    pop   = valid && rdy;
    req   = !redir && (m_q.size() + int'(m_inf) - int'(pop) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(req));
    chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
    chk("if_valid", 32'(if_valid), 32'(valid));
    chk("if_pc", 32'(if_pc), 32'(epc));
    chk("if_inst", 32'(if_inst), 32'(einst));
    chk("if_next_pc", 32'(if_next_pc), 32'(16'(epc + 16'd1)));
`ifdef IF_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_stall);
    chk("perf_flush", perf_flush_cnt, m_flush);
    if (valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (redir && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
    m_last_pc = epc; m_last_inst = einst;
    if (redir) begin
      m_q.delete();
      m_inf   = 1'b0;
      m_fetch = jr ? tjr : (j ? tj : tbt);
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inf) m_q.push_back(m_inf_pc);
      m_inf = req;
      if (req) begin
        m_inf_pc = m_fetch;
        m_fetch  = m_fetch + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 0, 0, 0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst = 1'b0;

    // Streaming from reset, then backpressure and release.
    run(12, 1'b1);
    run(10, 1'b0);
    run(8, 1'b1);

    // Jump while entries are queued and a request is in flight.
    run(3, 1'b0);
    step(1'b0, 0, 1, 0, 16'h0, 16'h0100, 16'h0);
    run(6, 1'b1);

    // All redirect sources at once: register jump wins.
    step(1'b1, 1, 1, 1, 16'h0010, 16'h0020, 16'h0030);
    run(5, 1'b1);
    step(1'b1, 0, 1, 1, 16'h0010, 16'h0020, 16'h0030);
    run(4, 1'b1);
    step(1'b0, 0, 0, 1, 16'h0010, 16'h0020, 16'h0030);
    run(4, 1'b1);

    // Address wrap at the top of the PC space.
    step(1'b1, 0, 1, 0, 16'h0, 16'hFFFE, 16'h0);
    run(7, 1'b1);

    // Random traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      int r;
      bit rdy, jr, j, bt;
      r   = int'($urandom_range(0, 99));
      rdy = $urandom_range(0, 9) < 6;
      jr  = (r < 3) || (r == 97);
      j   = (r >= 3 && r < 6) || (r >= 97);
      bt  = (r >= 6 && r < 9) || (r >= 98);
      step(rdy, jr, j, bt, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Asynchronous reset with a full queue.
    run(2, 1'b1);
    run(8, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
